// File: rtl/route_compute_unit.sv
// Per-input-port route compute and wormhole flow control.
// Decodes XY routes for head flits, holds the output port until the tail, and forwards flits registered.
module route_compute_unit #(
  parameter int DATA_WIDTH  = 16,
  parameter int COORD_WIDTH = 3,
  parameter int MY_X        = 0,
  parameter int MY_Y        = 0,
  parameter int NUM_PORTS   = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  buf_empty_i,
  input  logic [DATA_WIDTH-1:0] buf_data_i,
  output logic                  buf_read_o,
  input  logic                  out_ready_i,
  input  logic                  grant_i,
  output logic [NUM_PORTS-1:0]  req_o,
  output logic [DATA_WIDTH-1:0] flit_o,
  output logic                  flit_valid_o,
  output logic                  err_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_ACTIVE = 2'd2
  } state_e;

  localparam int P_LOCAL = 0;
  localparam int P_NORTH = 1;
  localparam int P_EAST  = 2;
  localparam int P_SOUTH = 3;
  localparam int P_WEST  = 4;
  localparam int DX_LSB  = DATA_WIDTH - 2 - COORD_WIDTH;
  localparam int DY_LSB  = DX_LSB - COORD_WIDTH;
  localparam logic [COORD_WIDTH-1:0] MY_X_C = COORD_WIDTH'(MY_X);
  localparam logic [COORD_WIDTH-1:0] MY_Y_C = COORD_WIDTH'(MY_Y);

  state_e                  state_q;
  logic [NUM_PORTS-1:0]    route_q;
  logic [NUM_PORTS-1:0]    req_q;
  logic [DATA_WIDTH-1:0]   flit_q;
  logic                    flit_valid_q;
  logic                    err_q;

  logic [1:0]              flit_type;
  logic [COORD_WIDTH-1:0]  dest_x;
  logic [COORD_WIDTH-1:0]  dest_y;
  logic [NUM_PORTS-1:0]    route_new;

  function automatic logic [NUM_PORTS-1:0] xy_route(input logic [COORD_WIDTH-1:0] dx,
                                                    input logic [COORD_WIDTH-1:0] dy);
    logic [NUM_PORTS-1:0] r;
    r = '0;
    if (dx > MY_X_C)      r[P_EAST]  = 1'b1;
    else if (dx < MY_X_C) r[P_WEST]  = 1'b1;
    else if (dy > MY_Y_C) r[P_NORTH] = 1'b1;
    else if (dy < MY_Y_C) r[P_SOUTH] = 1'b1;
    else                  r[P_LOCAL] = 1'b1;
    return r;
  endfunction

  assign flit_type = buf_data_i[DATA_WIDTH-1 -: 2];
  assign dest_x    = buf_data_i[DX_LSB +: COORD_WIDTH];
  assign dest_y    = buf_data_i[DY_LSB +: COORD_WIDTH];
  assign route_new = xy_route(dest_x, dest_y);

  // Pop decision: stray BODY/TAIL flits are drained in IDLE; packet flits move when downstream is ready.
  always_comb begin
    buf_read_o = 1'b0;
    if (reset && !buf_empty_i) begin
      case (state_q)
        ST_IDLE:   buf_read_o = ~flit_type[0];
        ST_ACTIVE: buf_read_o = out_ready_i;
        default:   buf_read_o = 1'b0;
      endcase
    end else begin
      buf_read_o = 1'b0;
    end
  end

  // Wormhole FSM with registered request, flit and error outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      route_q      <= '0;
      req_q        <= '0;
      flit_q       <= '0;
      flit_valid_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      flit_valid_q <= 1'b0;
      err_q        <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!buf_empty_i) begin
            if (flit_type[0]) begin
              route_q <= route_new;
              req_q   <= route_new;
              state_q <= ST_REQ;
            end else begin
              err_q   <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          if (grant_i) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          req_q <= route_q;
          if (buf_read_o) begin
            flit_q       <= buf_data_i;
            flit_valid_q <= 1'b1;
            // A HEAD seen here has type[1]=0, so it passes through like a BODY.
            if (flit_type[1]) begin
              state_q <= ST_IDLE;
              req_q   <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          req_q   <= '0;
        end
      endcase
    end
  end

  assign req_o        = req_q;
  assign flit_o       = flit_q;
  assign flit_valid_o = flit_valid_q;
  assign err_o        = err_q;

endmodule
